// File: rtl/input_mapper_pkg.sv
// input_mapper_pkg
//   Shared constants for the input mapper: joystick bit positions, the
//   internal key-latch vector layout, and the scancodes of both keyboard sets.
//   decode_set1/decode_set2 map one PS/2 event to a one-hot key-latch mask.
package input_mapper_pkg;

  // Joystick word layout, per player (16 bits each)
  localparam int JOY_WIDTH = 16;
  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_BTN0  = 4;
  localparam int JOY_START = 12;
  localparam int JOY_COIN  = 13;

  // Key-latch vector layout (one latch per mapped key of a set)
  localparam int KEY_BTNS  = 4;
  localparam int KL_RIGHT  = 0;
  localparam int KL_LEFT   = 1;
  localparam int KL_DOWN   = 2;
  localparam int KL_UP     = 3;
  localparam int KL_BTN0   = 4;
  localparam int KL_START  = 8;
  localparam int KL_COIN   = 9;
  localparam int KL_WIDTH  = 10;

  typedef logic [KL_WIDTH-1:0] key_vec_t;

  // Keyboard set 1 (arrows are extended codes)
  localparam logic [7:0] S1_UP    = 8'h75;
  localparam logic [7:0] S1_DOWN  = 8'h72;
  localparam logic [7:0] S1_LEFT  = 8'h6B;
  localparam logic [7:0] S1_RIGHT = 8'h74;
  localparam logic [7:0] S1_BTN0  = 8'h14;
  localparam logic [7:0] S1_BTN1  = 8'h11;
  localparam logic [7:0] S1_BTN2  = 8'h29;
  localparam logic [7:0] S1_BTN3  = 8'h12;
  localparam logic [7:0] S1_START = 8'h16;
  localparam logic [7:0] S1_COIN  = 8'h2E;

  // Keyboard set 2
  localparam logic [7:0] S2_UP    = 8'h2D;
  localparam logic [7:0] S2_DOWN  = 8'h2B;
  localparam logic [7:0] S2_LEFT  = 8'h23;
  localparam logic [7:0] S2_RIGHT = 8'h34;
  localparam logic [7:0] S2_BTN0  = 8'h1C;
  localparam logic [7:0] S2_BTN1  = 8'h1B;
  localparam logic [7:0] S2_BTN2  = 8'h15;
  localparam logic [7:0] S2_BTN3  = 8'h1D;
  localparam logic [7:0] S2_START = 8'h1E;
  localparam logic [7:0] S2_COIN  = 8'h36;

  // Arrows only match with the extended prefix; other keys ignore it
  function automatic key_vec_t decode_set1(input logic ext, input logic [7:0] code);
    key_vec_t hit;
    hit = '0;
    case (code)
      S1_UP:    hit[KL_UP]      = ext;
      S1_DOWN:  hit[KL_DOWN]    = ext;
      S1_LEFT:  hit[KL_LEFT]    = ext;
      S1_RIGHT: hit[KL_RIGHT]   = ext;
      S1_BTN0:  hit[KL_BTN0]    = 1'b1;
      S1_BTN1:  hit[KL_BTN0+1]  = 1'b1;
      S1_BTN2:  hit[KL_BTN0+2]  = 1'b1;
      S1_BTN3:  hit[KL_BTN0+3]  = 1'b1;
      S1_START: hit[KL_START]   = 1'b1;
      S1_COIN:  hit[KL_COIN]    = 1'b1;
      default:  hit = '0;
    endcase
    return hit;
  endfunction

  function automatic key_vec_t decode_set2(input logic [7:0] code);
    key_vec_t hit;
    hit = '0;
    case (code)
      S2_UP:    hit[KL_UP]      = 1'b1;
      S2_DOWN:  hit[KL_DOWN]    = 1'b1;
      S2_LEFT:  hit[KL_LEFT]    = 1'b1;
      S2_RIGHT: hit[KL_RIGHT]   = 1'b1;
      S2_BTN0:  hit[KL_BTN0]    = 1'b1;
      S2_BTN1:  hit[KL_BTN0+1]  = 1'b1;
      S2_BTN2:  hit[KL_BTN0+2]  = 1'b1;
      S2_BTN3:  hit[KL_BTN0+3]  = 1'b1;
      S2_START: hit[KL_START]   = 1'b1;
      S2_COIN:  hit[KL_COIN]    = 1'b1;
      default:  hit = '0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/input_mapper_coin_stretcher.sv
// coin_stretcher
//   Turns a rising edge of a raw coin signal into a pulse of exactly
//   COIN_PULSE clock cycles. Edges during a pulse are ignored and a held
//   coin never retriggers.
//   Ports: clk, reset_n (async, active-low), coin_raw (level in),
//          coin (registered pulse out).
module coin_stretcher #(
  parameter int COIN_PULSE = 1600000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic coin_raw,
  output logic coin
);

  localparam int CW = $clog2(COIN_PULSE + 1);

  logic [CW-1:0] cnt;
  logic          raw_q;
  logic          start_pulse;

  assign start_pulse = coin_raw & ~raw_q & (cnt == '0);

  // raw_q resets high so a coin held through reset must first be seen low
  // before it can count as a new rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      raw_q <= 1'b1;
      coin  <= 1'b0;
    end else begin
      raw_q <= coin_raw;
      if (start_pulse) begin
        cnt  <= CW'(COIN_PULSE);
        coin <= 1'b1;
      end else if (cnt != '0) begin
        cnt  <= cnt - CW'(1);
        coin <= (cnt > CW'(1));
      end else begin
        coin <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/input_mapper.sv
// input_mapper
//   Merges PS/2 keyboard events and per-player joystick words into registered
//   per-player direction, button, start and coin outputs.
//   Ports: clk, reset_n (async, active-low); ps2_key[10:0] {toggle, pressed,
//          extended, scancode}; joystick[PLAYERS*16]; key_share (1: set 1
//          drives players 0 and 1, 0: set 1 -> player 0, set 2 -> player 1);
//          autofire_mask[BUTTONS] (autofire build only);
//          dir[PLAYERS*4] {up,down,right,left}; buttons[PLAYERS*BUTTONS];
//          start[PLAYERS]; coin[PLAYERS] (stretched pulse).
//   Build option: define INPUT_MAPPER_AUTOFIRE_EN to add per-button autofire.
module input_mapper
  import input_mapper_pkg::*;
#(
  parameter int PLAYERS    = 2,
  parameter int BUTTONS    = 4,
  parameter int COIN_PULSE = 1600000
`ifdef INPUT_MAPPER_AUTOFIRE_EN
  ,
  parameter int AUTOFIRE_DIV = 3200000
`endif
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [10:0]                  ps2_key,
  input  logic [PLAYERS*JOY_WIDTH-1:0] joystick,
  input  logic                         key_share,
`ifdef INPUT_MAPPER_AUTOFIRE_EN
  input  logic [BUTTONS-1:0]           autofire_mask,
`endif
  output logic [PLAYERS*4-1:0]         dir,
  output logic [PLAYERS*BUTTONS-1:0]   buttons,
  output logic [PLAYERS-1:0]           start,
  output logic [PLAYERS-1:0]           coin
);

  logic     toggle_q;
  logic     key_event;
  key_vec_t set1_q, set2_q;
  key_vec_t set1_hit, set2_hit;
  key_vec_t player_keys [PLAYERS];

  logic [PLAYERS-1:0]         raw_left, raw_right, raw_up, raw_down;
  logic [PLAYERS-1:0]         raw_start, raw_coin;
  logic [PLAYERS*BUTTONS-1:0] raw_btn, btn_next;

  assign key_event = ps2_key[10] ^ toggle_q;
  assign set1_hit  = decode_set1(ps2_key[8], ps2_key[7:0]);
  assign set2_hit  = decode_set2(ps2_key[7:0]);

  // The toggle register tracks ps2_key[10] even in reset, so releasing reset
  // never looks like a fresh event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q <= ps2_key[10];
      set1_q   <= '0;
      set2_q   <= '0;
    end else begin
      toggle_q <= ps2_key[10];
      if (key_event) begin
        set1_q <= (set1_q & ~set1_hit) | (set1_hit & {KL_WIDTH{ps2_key[9]}});
        set2_q <= (set2_q & ~set2_hit) | (set2_hit & {KL_WIDTH{ps2_key[9]}});
      end
    end
  end

  // Keyboard routing: players 2 and up only see their joystick.
  always_comb begin
    for (int p = 0; p < PLAYERS; p++) begin
      player_keys[p] = '0;
      if (p == 0)      player_keys[p] = set1_q;
      else if (p == 1) player_keys[p] = key_share ? set1_q : set2_q;
    end
  end

  always_comb begin
    raw_left  = '0;
    raw_right = '0;
    raw_up    = '0;
    raw_down  = '0;
    raw_start = '0;
    raw_coin  = '0;
    raw_btn   = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      raw_right[p] = joystick[p*JOY_WIDTH + JOY_RIGHT] | player_keys[p][KL_RIGHT];
      raw_left[p]  = joystick[p*JOY_WIDTH + JOY_LEFT]  | player_keys[p][KL_LEFT];
      raw_down[p]  = joystick[p*JOY_WIDTH + JOY_DOWN]  | player_keys[p][KL_DOWN];
      raw_up[p]    = joystick[p*JOY_WIDTH + JOY_UP]    | player_keys[p][KL_UP];
      raw_start[p] = joystick[p*JOY_WIDTH + JOY_START] | player_keys[p][KL_START];
      raw_coin[p]  = joystick[p*JOY_WIDTH + JOY_COIN]  | player_keys[p][KL_COIN];
      for (int b = 0; b < BUTTONS; b++) begin
        // keyboard only provides four buttons; the modulo keeps the index legal
        raw_btn[p*BUTTONS + b] = joystick[p*JOY_WIDTH + JOY_BTN0 + b] |
                                 ((b < KEY_BTNS) ? player_keys[p][KL_BTN0 + (b % KEY_BTNS)] : 1'b0);
      end
    end
  end

`ifdef INPUT_MAPPER_AUTOFIRE_EN
  localparam int AFW = $clog2(AUTOFIRE_DIV + 1);

  logic [AFW-1:0]             af_cnt;
  logic                       af_phase, af_phase_next, af_rise, af_wrap;
  logic [PLAYERS*BUTTONS-1:0] af_mask_all, btn_prev;

  always_comb begin
    for (int p = 0; p < PLAYERS; p++) begin
      af_mask_all[p*BUTTONS +: BUTTONS] = autofire_mask;
    end
  end

  // A fresh press of any masked button forces the phase high and restarts
  // the divider, so the first shot is immediate.
  assign af_rise       = |(raw_btn & af_mask_all & ~btn_prev);
  assign af_wrap       = (af_cnt == AFW'(AUTOFIRE_DIV - 1));
  assign af_phase_next = af_rise | (af_wrap ? ~af_phase : af_phase);
  assign btn_next      = raw_btn & (~af_mask_all | {(PLAYERS*BUTTONS){af_phase_next}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      af_cnt   <= '0;
      af_phase <= 1'b0;
      btn_prev <= '0;
    end else begin
      btn_prev <= raw_btn;
      af_phase <= af_phase_next;
      af_cnt   <= (af_rise || af_wrap) ? '0 : af_cnt + AFW'(1);
    end
  end
`else
  assign btn_next = raw_btn;
`endif

  // Opposing directions cancel to neutral.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir     <= '0;
      buttons <= '0;
      start   <= '0;
    end else begin
      for (int p = 0; p < PLAYERS; p++) begin
        dir[p*4 + 0] <= raw_left[p]  & ~raw_right[p];
        dir[p*4 + 1] <= raw_right[p] & ~raw_left[p];
        dir[p*4 + 2] <= raw_down[p]  & ~raw_up[p];
        dir[p*4 + 3] <= raw_up[p]    & ~raw_down[p];
      end
      buttons <= btn_next;
      start   <= raw_start;
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_coin
    coin_stretcher #(
      .COIN_PULSE(COIN_PULSE)
    ) u_coin (
      .clk      (clk),
      .reset_n  (reset_n),
      .coin_raw (raw_coin[p]),
      .coin     (coin[p])
    );
  end

  // Joystick bits beyond the mapped buttons and unrouted latches are unused.
  logic unused_inputs;
  assign unused_inputs = ^{joystick, set1_q, set2_q};

endmodule
